// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store with programmable latency,
// byte/half/word access on a byte-lane array, and a valid/ready response channel.
module data_mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        weReg;
  logic [31:0] addrReg;
  logic [31:0] wdataReg;
  logic [2:0]  funct3Reg;

  logic        accWe;
  logic [31:0] accAddr;
  logic [31:0] accWdata;
  logic [2:0]  accF3;
  logic [ADDR_BITS-1:0] accIdx;
  logic        accErr;
  logic [31:0] loadData;
  logic [31:0] shifted;
  logic [3:0]  memBe;
  logic [31:0] memWdata;
  logic        enterResp;
  logic        memWe;
  wire  [31:0] memWord;
  wire         unusedAddrBits;

  assign req_ready = (state == IDLE);

  // With LATENCY==1 the access happens on the accepting edge, so use the live request.
  assign accWe    = (state == IDLE) ? req_we     : weReg;
  assign accAddr  = (state == IDLE) ? req_addr   : addrReg;
  assign accWdata = (state == IDLE) ? req_wdata  : wdataReg;
  assign accF3    = (state == IDLE) ? req_funct3 : funct3Reg;
  assign accIdx   = accAddr[ADDR_BITS+1:2];
  assign unusedAddrBits = ^accAddr[31:ADDR_BITS+2];

  assign enterResp = ((state == IDLE) && req_valid && (LATENCY == 1)) ||
                     ((state == WAIT) && (cnt == 4'd0));
  assign memWe = enterResp && accWe && !accErr && !rst;

  always_comb begin
    accErr   = 1'b0;
    loadData = 32'd0;
    memBe    = 4'b0000;
    memWdata = 32'd0;
    shifted  = memWord >> {accAddr[1:0], 3'b000};
    if (accWe) begin
      case (accF3)
        3'd0: begin
          memBe    = 4'b0001 << accAddr[1:0];
          memWdata = {4{accWdata[7:0]}};
        end
        3'd1: begin
          accErr   = accAddr[0];
          memBe    = accAddr[1] ? 4'b1100 : 4'b0011;
          memWdata = {2{accWdata[15:0]}};
        end
        3'd2: begin
          accErr   = (accAddr[1:0] != 2'b00);
          memBe    = 4'b1111;
          memWdata = accWdata;
        end
        default: accErr = 1'b1;
      endcase
    end else begin
      case (accF3)
        3'd0: loadData = {{24{shifted[7]}}, shifted[7:0]};
        3'd4: loadData = {24'd0, shifted[7:0]};
        3'd1: begin
          accErr   = accAddr[0];
          loadData = {{16{shifted[15]}}, shifted[15:0]};
        end
        3'd5: begin
          accErr   = accAddr[0];
          loadData = {16'd0, shifted[15:0]};
        end
        3'd2: begin
          accErr   = (accAddr[1:0] != 2'b00);
          loadData = memWord;
        end
        default: accErr = 1'b1;
      endcase
    end
  end

  // One array per byte lane gives natural byte-enable writes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gLane
      logic [7:0] laneMem [DEPTH];
      always_ff @(posedge clk) begin
        if (memWe && memBe[gi]) begin
          laneMem[accIdx] <= memWdata[8*gi +: 8];
        end
      end
      assign memWord[8*gi +: 8] = laneMem[accIdx];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      weReg      <= 1'b0;
      addrReg    <= 32'd0;
      wdataReg   <= 32'd0;
      funct3Reg  <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            weReg     <= req_we;
            addrReg   <= req_addr;
            wdataReg  <= req_wdata;
            funct3Reg <= req_funct3;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (enterResp) begin
        resp_valid <= 1'b1;
        resp_err   <= accErr;
        resp_rdata <= (accErr || accWe) ? 32'd0 : loadData;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (ADDR_BITS=10, LATENCY=2) with immediate-assertion checks.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int nAsserts = 0;
  int nFail    = 0;

  data_mem_responder #(.ADDR_BITS(10), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for the response and let it be consumed.
  // lat counts edges up to resp_valid, counting the accepting edge as the first.
  task automatic doReq(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                       output int lat);
    req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    $display("txn we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             we, f3, addr, wdata, rdata, err, lat);
    @(posedge clk); #1;
  endtask

  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] expData, input logic expErr);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    doReq(we, addr, wdata, f3, rdata, err, lat);
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    check({tag, "_data"}, rdata, expData);
    check({tag, "_err"}, 32'(err), 32'(expErr));
  endtask

  initial begin
    int spurious;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; req_funct3 = 3'd0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    spurious = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (resp_valid) spurious++;
    end
    check("idle_spurious", 32'(spurious), 32'd0);

    // word store/load
    access("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 32'd0, 1'b0);
    access("lw10", 1'b0, 32'h10, 32'd0, 3'd2, 32'hDEADBEEF, 1'b0);

    // sub-word loads and byte store
    access("sw20", 1'b1, 32'h20, 32'h8001F080, 3'd2, 32'd0, 1'b0);
    access("lb20", 1'b0, 32'h20, 32'd0, 3'd0, 32'hFFFFFF80, 1'b0);
    access("lbu20", 1'b0, 32'h20, 32'd0, 3'd4, 32'h00000080, 1'b0);
    access("lh22", 1'b0, 32'h22, 32'd0, 3'd1, 32'hFFFF8001, 1'b0);
    access("lhu22", 1'b0, 32'h22, 32'd0, 3'd5, 32'h00008001, 1'b0);
    access("lbu23", 1'b0, 32'h23, 32'd0, 3'd4, 32'h00000080, 1'b0);
    access("sb21", 1'b1, 32'h21, 32'h00000055, 3'd0, 32'd0, 1'b0);
    access("lw20", 1'b0, 32'h20, 32'd0, 3'd2, 32'h80015580, 1'b0);
    access("sh22", 1'b1, 32'h22, 32'h0000BEEF, 3'd1, 32'd0, 1'b0);
    access("lw20b", 1'b0, 32'h20, 32'd0, 3'd2, 32'hBEEF5580, 1'b0);

    // misaligned and illegal funct3
    access("lw13", 1'b0, 32'h13, 32'd0, 3'd2, 32'd0, 1'b1);
    access("lh21", 1'b0, 32'h21, 32'd0, 3'd1, 32'd0, 1'b1);
    access("sh11", 1'b1, 32'h11, 32'h0000AAAA, 3'd1, 32'd0, 1'b1);
    access("ld_f3_6", 1'b0, 32'h10, 32'd0, 3'd6, 32'd0, 1'b1);
    access("st_f3_3", 1'b1, 32'h10, 32'h12345678, 3'd3, 32'd0, 1'b1);
    access("lw10_kept", 1'b0, 32'h10, 32'd0, 3'd2, 32'hDEADBEEF, 1'b0);

    // backpressure: response held, concurrent request ignored
    resp_ready = 1'b0;
    req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    begin
      int waitCnt;
      waitCnt = 0;
      while (!resp_valid && waitCnt < 20) begin
        @(posedge clk); #1;
        waitCnt++;
      end
      check("bp_resp_seen", 32'(resp_valid), 32'd1);
    end
    req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h11111111; req_funct3 = 3'd2;
    req_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_rdata", resp_rdata, 32'hDEADBEEF);
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(resp_valid), 32'd0);
    check("bp_release_ready", 32'(req_ready), 32'd1);
    $display("txn backpressure release");
    access("lw10_after_bp", 1'b0, 32'h10, 32'd0, 3'd2, 32'hDEADBEEF, 1'b0);

    // reset during WAIT aborts the store
    access("sw30_zero", 1'b1, 32'h30, 32'd0, 3'd2, 32'd0, 1'b0);
    req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h00001234; req_funct3 = 3'd2;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_in_wait", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_idle", 32'(req_ready), 32'd1);
    check("abort_valid", 32'(resp_valid), 32'd0);
    spurious = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_valid) spurious++;
    end
    check("abort_spurious", 32'(spurious), 32'd0);
    $display("txn sw 0x30 aborted by reset");
    access("lw30", 1'b0, 32'h30, 32'd0, 3'd2, 32'd0, 1'b0);

    // address aliasing modulo 4 KiB
    access("sw1000", 1'b1, 32'h1000, 32'h00000077, 3'd2, 32'd0, 1'b0);
    access("lw0", 1'b0, 32'h0, 32'd0, 3'd2, 32'h00000077, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
